// File: rtl/parallel_to_serial_shifter.sv
// Parallel-in / serial-out transmitter feeding the SIPO receiver.
// A word taken through a valid/ready handshake is sent one bit per clock,
// LSB first (right shift) or MSB first (left shift). A new word may be
// accepted on the last bit of the current frame, so frames run back to back.
module parallel_to_serial_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d_in,
  input  logic             left_or_right,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The counter is only ever loaded with this value; it counts down to 0.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic             accept;

  // Frame status comes straight from the state and counter registers.
  assign s_valid    = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT);
  assign s_last     = (state_q == SHIFT) && (cnt_q == '0);
  assign load_ready = (state_q == IDLE) || s_last;
  assign accept     = load_valid && load_ready;

  // Serial bit: end of the register selected by the latched direction, 0 when idle.
  always_comb begin
    s_out = 1'b0;
    if (state_q == SHIFT) begin
      s_out = dir_q ? sreg_q[0] : sreg_q[WIDTH-1];
    end
  end

  // Shifted register contents for the next bit, zero-filled at the vacated end.
  always_comb begin
    if (dir_q) begin
      sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
    end else begin
      sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
    end
  end

  // Two-state framing FSM with word, direction and bit counter capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SHIFT;
            sreg_q  <= d_in;
            dir_q   <= left_or_right;
            cnt_q   <= LAST_CNT;
          end
        end
        SHIFT: begin
          if (accept) begin
            // Only reachable on the last bit: reload with no idle gap.
            sreg_q <= d_in;
            dir_q  <= left_or_right;
            cnt_q  <= LAST_CNT;
          end else if (cnt_q != '0) begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_q - 1'b1;
          end else begin
            state_q <= IDLE;
            sreg_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
